stopwatch_counter: RTL and testbench
====================================

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 The block SHALL take parameter SYNC_STAGES, default 2, giving the synchronizer depth (2..4) applied to tick_in, Key1 and Key2.
REQ-002 The block SHALL take parameter MAX_MIN, default 59, giving the highest minutes value (0..99) before wrap.
REQ-003 clkin  input  1  system clock; every flop in the block is clocked on its rising edge.
REQ-004 Reset  input  1  reset, synchronous to clkin, active-high.
REQ-005 tick_in  input  1  divided 10 ms clock from the upstream divider; asynchronous to the block's logic.
REQ-006 Key1  input  1  start/stop pushbutton, active-low.
REQ-007 Key2  input  1  lap/clear pushbutton, active-low.
REQ-008 cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens  output  4 each  BCD display digits.
REQ-009 running  output  1  high while the state is RUN or LAP.
REQ-010 overflow  output  1  sticky flag, set on a wrap at MAX_MIN:59.99.

Function
REQ-011 tick_in, Key1 and Key2 SHALL each pass through SYNC_STAGES flops, followed by one edge-detect flop.
REQ-012 A tick event SHALL be one rising edge of synchronized tick_in, producing a 1-cycle pulse.
REQ-013 A key event SHALL be one falling edge of a synchronized key, producing a 1-cycle pulse.
REQ-014 States SHALL be IDLE, RUN, PAUSE and LAP, encoded in 2 bits.
REQ-015 Transitions SHALL be:
- IDLE --Key1--> RUN
- RUN --Key1--> PAUSE
- PAUSE --Key1--> RUN
- PAUSE --Key2--> IDLE, clearing the count and overflow
- RUN --Key2--> LAP, only when LAP_EN is defined
- LAP --Key2--> RUN
- LAP --Key1--> PAUSE
REQ-016 The internal count SHALL advance by 0.01 s on each tick event only while the state is RUN or LAP; the state used is the one before any same-cycle transition.
REQ-017 Digit carries SHALL be:
- cs_ones 9→0 carries into cs_tens.
- cs_tens 9→0 carries into sec_ones.
- sec_ones 9→0 carries into sec_tens.
- sec_tens 5→0 carries into minutes.
- Minutes are held as a BCD pair, min_tens:min_ones.
REQ-018 At count MAX_MIN:59.99, a tick event SHALL:
- set every digit to 0;
- set overflow to 1;
- leave the state unchanged.
REQ-019 In IDLE, RUN and PAUSE, the outputs SHALL equal the internal count, registered one cycle after the count changes.
REQ-020 In LAP, the outputs SHALL hold the value captured on LAP entry while the internal count keeps advancing.
REQ-021 On LAP→RUN, the outputs SHALL resume tracking the internal count on the next cycle.
REQ-022 Key1 and Key2 events in the same cycle: Key1 SHALL take priority and Key2 SHALL be dropped.
REQ-023 A key event in a state with no listed transition SHALL be ignored.
REQ-024 Total latency from a tick_in rising edge to the digit update SHALL be SYNC_STAGES+2 clkin cycles.
REQ-025 Held keys SHALL produce only one event.
REQ-026 Contact bounce SHALL NOT be filtered; this block does not debounce.

Reset
REQ-027 While Reset=1, the block SHALL force:
- state to IDLE;
- all digits to 0;
- running and overflow to 0;
- all synchronizer and edge flops to their idle levels (tick 0, keys 1).
REQ-028 Reset asserted mid-count or in LAP SHALL discard the count and the frozen lap value within the same cycle.
REQ-029 No event SHALL be generated on the first cycle after Reset deasserts.

Configuration
REQ-030 With macro STOPWATCH_LAP_EN defined, the LAP state and output freeze SHALL be compiled in.
REQ-031 Without STOPWATCH_LAP_EN, the LAP state and lap register SHALL be absent, and Key2 in RUN SHALL be ignored.

Verification
REQ-032 Reset, Key1 pulse, 150 tick edges → state RUN; digits 00:01.50; running=1.
REQ-033 Preload 59:59.98 via ticks, then 2 more tick edges → 00:00.00; overflow=1; state RUN.
REQ-034 RUN at 00:02.00, Key1 → PAUSE; 10 tick edges → digits stay 00:02.00; then Key2 → IDLE, all 0, overflow=0.
REQ-035 With LAP_EN: RUN at 00:03.00, Key2 → outputs frozen at 00:03.00; 100 ticks later, Key2 → outputs 00:04.00.
REQ-036 Key1 and Key2 fall in the same cycle in RUN → PAUSE only; a tick in that same cycle is still counted.
REQ-037 Reset pulsed while RUN at 00:45.67 → all outputs 0 on the next cycle; state IDLE.

Source files
------------

// File: rtl/stopwatch_counter_if.sv
// Stopwatch bus: asynchronous tick/key inputs toward the counter and the BCD display digits back.
// The master drives tick/keys and reads the display; the counter block is the slave.
interface stopwatch_counter_if;
  logic       tick_in;
  logic       Key1;
  logic       Key2;
  logic [3:0] cs_ones;
  logic [3:0] cs_tens;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       overflow;

  modport master (
    output tick_in, Key1, Key2,
    input  cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens, running, overflow
  );

  modport slave (
    input  tick_in, Key1, Key2,
    output cs_ones, cs_tens, sec_ones, sec_tens, min_ones, min_tens, running, overflow
  );
endinterface

// File: rtl/stopwatch_counter.sv
// BCD stopwatch (MM:SS.cc) counting 10 ms ticks, with start/stop and lap/clear keys.
// Optional lap-freeze display is compiled in with STOPWATCH_LAP_EN.
//
// state | meaning
// IDLE  | cleared, not counting
// RUN   | counting, display tracks the count
// PAUSE | count held, display tracks the count
// LAP   | counting, display frozen at the lap-entry value (STOPWATCH_LAP_EN only)
module stopwatch_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 59
) (
  input  logic                clkin,
  input  logic                Reset,
  stopwatch_counter_if.slave  bus
);

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
`endif

  localparam logic [3:0]  MAX_MT  = 4'(MAX_MIN / 10);
  localparam logic [3:0]  MAX_MO  = 4'(MAX_MIN % 10);
  localparam logic [23:0] CNT_MAX = {MAX_MT, MAX_MO, 16'h5999};

  logic [SYNC_STAGES-1:0] tick_sync_q, key1_sync_q, key2_sync_q;
  logic                   tick_edge_q, key1_edge_q, key2_edge_q;
  logic                   tick_ev, key1_ev, key2_ev;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_inc;
  logic [23:0] disp_q;
  logic        running_q, overflow_q;
  logic        at_max, counting, clear_cnt;

  always_ff @(posedge clkin) begin
    if (Reset) begin
      tick_sync_q <= '0;
      key1_sync_q <= '1;
      key2_sync_q <= '1;
      tick_edge_q <= 1'b0;
      key1_edge_q <= 1'b1;
      key2_edge_q <= 1'b1;
    end else begin
      tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], bus.tick_in};
      key1_sync_q <= {key1_sync_q[SYNC_STAGES-2:0], bus.Key1};
      key2_sync_q <= {key2_sync_q[SYNC_STAGES-2:0], bus.Key2};
      tick_edge_q <= tick_sync_q[SYNC_STAGES-1];
      key1_edge_q <= key1_sync_q[SYNC_STAGES-1];
      key2_edge_q <= key2_sync_q[SYNC_STAGES-1];
    end
  end

  // Keys are active-low: an event is the falling edge of the synchronized level.
  assign tick_ev = tick_sync_q[SYNC_STAGES-1] & ~tick_edge_q;
  assign key1_ev = ~key1_sync_q[SYNC_STAGES-1] & key1_edge_q;
  assign key2_ev = ~key2_sync_q[SYNC_STAGES-1] & key2_edge_q;

  // BCD increment, digit order {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones}.
  always_comb begin
    cnt_inc = cnt_q;
    at_max  = (cnt_q == CNT_MAX);
    if (at_max) begin
      cnt_inc = '0;
    end else if (cnt_q[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] != 4'd9) begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] != 4'd9) begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8] = 4'd0;
          if (cnt_q[15:12] != 4'd5) begin
            cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
          end else begin
            cnt_inc[15:12] = 4'd0;
            if (cnt_q[19:16] != 4'd9) begin
              cnt_inc[19:16] = cnt_q[19:16] + 4'd1;
            end else begin
              cnt_inc[19:16] = 4'd0;
              cnt_inc[23:20] = cnt_q[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  // Key1 wins over Key2 when both fall in the same cycle.
  always_comb begin
    state_d   = state_q;
    clear_cnt = 1'b0;
    case (state_q)
      IDLE: begin
        if (key1_ev) state_d = RUN;
      end
      RUN: begin
        if (key1_ev) state_d = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (key2_ev) state_d = LAP;
`endif
      end
      PAUSE: begin
        if (key1_ev) begin
          state_d = RUN;
        end else if (key2_ev) begin
          state_d   = IDLE;
          clear_cnt = 1'b1;
        end
      end
`ifdef STOPWATCH_LAP_EN
      LAP: begin
        if (key1_ev)      state_d = PAUSE;
        else if (key2_ev) state_d = RUN;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef STOPWATCH_LAP_EN
  assign counting = (state_q == RUN) || (state_q == LAP);
`else
  assign counting = (state_q == RUN);
`endif

  always_ff @(posedge clkin) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      disp_q     <= '0;
      running_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_cnt) begin
        cnt_q      <= '0;
        overflow_q <= 1'b0;
      end else if (tick_ev && counting) begin
        cnt_q <= cnt_inc;
        if (at_max) overflow_q <= 1'b1;
      end
`ifdef STOPWATCH_LAP_EN
      // disp_q doubles as the lap register: it stops tracking while in LAP.
      if (state_q != LAP) disp_q <= cnt_q;
      running_q <= (state_d == RUN) || (state_d == LAP);
`else
      disp_q    <= cnt_q;
      running_q <= (state_d == RUN);
`endif
    end
  end

  assign bus.cs_ones  = disp_q[3:0];
  assign bus.cs_tens  = disp_q[7:4];
  assign bus.sec_ones = disp_q[11:8];
  assign bus.sec_tens = disp_q[15:12];
  assign bus.min_ones = disp_q[19:16];
  assign bus.min_tens = disp_q[23:20];
  assign bus.running  = running_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench: instance A uses MAX_MIN=59, instance B uses MAX_MIN=1 to reach the wrap quickly.
module tb_stopwatch_counter;
  logic clkin = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  stopwatch_counter_if ifa ();
  stopwatch_counter_if ifb ();

  stopwatch_counter #(.SYNC_STAGES(2), .MAX_MIN(59)) dut_a (.clkin(clkin), .Reset(Reset), .bus(ifa));
  stopwatch_counter #(.SYNC_STAGES(2), .MAX_MIN(1))  dut_b (.clkin(clkin), .Reset(Reset), .bus(ifb));

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic set_tick(input int s, input logic v);
    if (s == 0) ifa.tick_in = v;
    else        ifb.tick_in = v;
  endtask

  task automatic set_keys(input int s, input logic k1, input logic k2);
    if (s == 0) begin ifa.Key1 = k1; ifa.Key2 = k2; end
    else        begin ifb.Key1 = k1; ifb.Key2 = k2; end
  endtask

  task automatic ticks(input int s, input int n);
    repeat (n) begin
      set_tick(s, 1'b1); cyc(1);
      set_tick(s, 1'b0); cyc(1);
    end
    cyc(5);
  endtask

  task automatic press(input int s, input bit p1, input bit p2);
    set_keys(s, !p1, !p2); cyc(4);
    set_keys(s, 1'b1, 1'b1); cyc(4);
  endtask

  function automatic logic [31:0] digits(input int s);
    if (s == 0)
      return {8'h0, ifa.min_tens, ifa.min_ones, ifa.sec_tens, ifa.sec_ones, ifa.cs_tens, ifa.cs_ones};
    return {8'h0, ifb.min_tens, ifb.min_ones, ifb.sec_tens, ifb.sec_ones, ifb.cs_tens, ifb.cs_ones};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    set_tick(0, 1'b0); set_keys(0, 1'b1, 1'b1);
    set_tick(1, 1'b0); set_keys(1, 1'b1, 1'b1);
    cyc(3);
    check("rst_digits", digits(0), 32'h000000);
    check("rst_running", {31'h0, ifa.running}, 32'h0);
    check("rst_overflow", {31'h0, ifa.overflow}, 32'h0);
    Reset = 1'b0;
    cyc(2);

    // Held Key1: exactly one event, so RUN (not RUN then PAUSE).
    set_keys(0, 1'b0, 1'b1); cyc(20);
    set_keys(0, 1'b1, 1'b1); cyc(4);
    check("held_key_run", {31'h0, ifa.running}, 32'h1);

    // Tick latency: SYNC_STAGES+2 = 4 cycles from drive to display.
    set_tick(0, 1'b1); cyc(3);
    check("lat_early", digits(0), 32'h000000);
    cyc(1);
    check("lat_update", digits(0), 32'h000001);
    set_tick(0, 1'b0); cyc(5);

    ticks(0, 149);
    check("run_150", digits(0), 32'h000150);
    check("run_150_running", {31'h0, ifa.running}, 32'h1);

    ticks(0, 50);
    check("run_200", digits(0), 32'h000200);
    press(0, 1, 0);
    check("pause_running", {31'h0, ifa.running}, 32'h0);
    ticks(0, 10);
    check("pause_hold", digits(0), 32'h000200);
    press(0, 0, 1);
    check("clear_digits", digits(0), 32'h000000);
    check("clear_overflow", {31'h0, ifa.overflow}, 32'h0);
    press(0, 0, 1);
    check("idle_key2_ignored", {31'h0, ifa.running}, 32'h0);

    press(0, 1, 0);
    ticks(0, 300);
    check("run_300", digits(0), 32'h000300);
    press(0, 0, 1);
`ifdef STOPWATCH_LAP_EN
    ticks(0, 100);
    check("lap_frozen", digits(0), 32'h000300);
    check("lap_running", {31'h0, ifa.running}, 32'h1);
    press(0, 0, 1);
    check("lap_resume", digits(0), 32'h000400);
`else
    check("key2_run_ignored", {31'h0, ifa.running}, 32'h1);
    ticks(0, 100);
    check("run_400", digits(0), 32'h000400);
`endif

    // Both keys and a tick land in the same cycle: PAUSE, tick still counted.
    set_keys(0, 1'b0, 1'b0); set_tick(0, 1'b1); cyc(1);
    set_tick(0, 1'b0); cyc(3);
    set_keys(0, 1'b1, 1'b1); cyc(6);
    check("both_keys_digits", digits(0), 32'h000401);
    check("both_keys_running", {31'h0, ifa.running}, 32'h0);
    ticks(0, 10);
    check("both_keys_paused", digits(0), 32'h000401);

    press(0, 1, 0);
    ticks(0, 4166);
    check("run_4567", digits(0), 32'h004567);
    Reset = 1'b1; cyc(1);
    check("reset_mid_digits", digits(0), 32'h000000);
    check("reset_mid_running", {31'h0, ifa.running}, 32'h0);
    Reset = 1'b0; cyc(2);
    ticks(0, 5);
    check("reset_idle", digits(0), 32'h000000);

    // Wrap at MAX_MIN:59.99 on the MAX_MIN=1 instance.
    press(1, 1, 0);
    ticks(1, 6000);
    check("min_carry", digits(1), 32'h010000);
    ticks(1, 5998);
    check("pre_wrap", digits(1), 32'h015998);
    check("pre_wrap_ovf", {31'h0, ifb.overflow}, 32'h0);
    ticks(1, 2);
    check("wrap_digits", digits(1), 32'h000000);
    check("wrap_ovf", {31'h0, ifb.overflow}, 32'h1);
    check("wrap_running", {31'h0, ifb.running}, 32'h1);
    ticks(1, 1);
    check("post_wrap", digits(1), 32'h000001);
    check("ovf_sticky", {31'h0, ifb.overflow}, 32'h1);
    press(1, 1, 0);
    press(1, 0, 1);
    check("ovf_cleared", {31'h0, ifb.overflow}, 32'h0);
    check("b_cleared", digits(1), 32'h000000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
